xaddrgen_loop: RTL and testbench



---
 rtl/xversat_pkg.sv | 31 +++
 rtl/xaddrgen_cnt.sv | 36 +++
 rtl/xaddrgen_loop.sv | 206 ++++++++++++++++++++
 tb/tb_xaddrgen_loop.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xversat_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : xversat_pkg                                                     |
// | Purpose  : Shared widths, address-generator state encoding and config type |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package xversat_pkg;

    localparam int ADDR_W   = 10;
    localparam int PERIOD_W = 10;
    localparam int DELAY_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } xaddrgen_state_e;

    // Per-run configuration record, also carried by the memory wrapper.
    typedef struct packed {
        logic [ADDR_W-1:0]   start;
        logic [PERIOD_W-1:0] per;
        logic [PERIOD_W-1:0] duty;
        logic [ADDR_W-1:0]   incr;
        logic [PERIOD_W-1:0] iter;
        logic [ADDR_W-1:0]   shift;
        logic [DELAY_W-1:0]  delay;
    } xaddrgen_cfg_t;

endpackage
`default_nettype wire

// File: rtl/xaddrgen_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : xaddrgen_cnt                                                    |
// | Purpose  : Loadable up-counter with terminal-count flag (cnt == last)      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module xaddrgen_cnt #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= din;
        end else if (inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;
    assign tc  = (r_cnt == last);

endmodule
`default_nettype wire

// File: rtl/xaddrgen_loop.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : xaddrgen_loop                                                   |
// | Purpose  : Two-level nested-loop memory address generator.                 |
// |            XADDRGEN_LOOP_DUTY_EN adds the duty port and k<duty gating.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module xaddrgen_loop #(
    parameter int ADDR_W   = xversat_pkg::ADDR_W,
    parameter int PERIOD_W = xversat_pkg::PERIOD_W,
    parameter int DELAY_W  = xversat_pkg::DELAY_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    output logic                done,
    input  logic [ADDR_W-1:0]   start,
    input  logic [PERIOD_W-1:0] per,
`ifdef XADDRGEN_LOOP_DUTY_EN
    input  logic [PERIOD_W-1:0] duty,
`endif
    input  logic [ADDR_W-1:0]   incr,
    input  logic [PERIOD_W-1:0] iter,
    input  logic [ADDR_W-1:0]   shift,
    input  logic [DELAY_W-1:0]  delay,
    output logic [ADDR_W-1:0]   addr,
    output logic                mem_en
);

    import xversat_pkg::xaddrgen_state_e;
    import xversat_pkg::ST_IDLE;
    import xversat_pkg::ST_WAIT;
    import xversat_pkg::ST_RUN;

    xaddrgen_state_e     r_state;
    xaddrgen_state_e     w_state_nxt;

    logic [ADDR_W-1:0]   r_start;
    logic [ADDR_W-1:0]   r_incr;
    logic [ADDR_W-1:0]   r_shift;
    logic [PERIOD_W-1:0] r_per;
    logic [PERIOD_W-1:0] r_iter;
    logic [DELAY_W-1:0]  r_delay;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_mem_en;

    logic [ADDR_W-1:0]   w_addr_nxt;
    logic                w_en_nxt;
    logic                w_load_cfg;
    logic                w_degen_in;
    logic                w_degen_cfg;
    logic                w_en_first_in;
    logic                w_en_first_cfg;
    logic                w_en_inner;

    logic [PERIOD_W-1:0] w_per_cnt;
    logic [PERIOD_W-1:0] w_iter_cnt;
    logic [DELAY_W-1:0]  w_dly_cnt;
    logic                w_per_tc;
    logic                w_iter_tc;
    logic                w_dly_tc;
    logic                w_unused_cnt;

`ifdef XADDRGEN_LOOP_DUTY_EN
    logic [PERIOD_W-1:0] r_duty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty <= '0;
        end else if (w_load_cfg) begin
            r_duty <= duty;
        end
    end

    // The enable for the next element is decided one cycle ahead, from k+1.
    assign w_en_first_in  = (duty != '0);
    assign w_en_first_cfg = (r_duty != '0);
    assign w_en_inner     = (PERIOD_W'(w_per_cnt + 1'b1) < r_duty);
`else
    assign w_en_first_in  = 1'b1;
    assign w_en_first_cfg = 1'b1;
    assign w_en_inner     = 1'b1;
`endif

    assign w_degen_in   = (per == '0) || (iter == '0);
    assign w_degen_cfg  = (r_per == '0) || (r_iter == '0);
    assign w_unused_cnt = ^{w_per_cnt, w_iter_cnt, w_dly_cnt};

    xaddrgen_cnt #(.W(DELAY_W)) u_dly_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (r_state != ST_WAIT),
        .din  ('0),
        .inc  (1'b1),
        .last (DELAY_W'(r_delay - 1'b1)),
        .cnt  (w_dly_cnt),
        .tc   (w_dly_tc)
    );

    xaddrgen_cnt #(.W(PERIOD_W)) u_per_cnt (
        .clk  (clk),
        .rst  (rst),
        .load ((r_state != ST_RUN) || w_per_tc),
        .din  ('0),
        .inc  (1'b1),
        .last (PERIOD_W'(r_per - 1'b1)),
        .cnt  (w_per_cnt),
        .tc   (w_per_tc)
    );

    xaddrgen_cnt #(.W(PERIOD_W)) u_iter_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (r_state != ST_RUN),
        .din  ('0),
        .inc  (w_per_tc),
        .last (PERIOD_W'(r_iter - 1'b1)),
        .cnt  (w_iter_cnt),
        .tc   (w_iter_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_cfg  = 1'b0;
        w_addr_nxt  = r_addr;
        w_en_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_load_cfg = 1'b1;
                    if (delay != '0) begin
                        w_state_nxt = ST_WAIT;
                    end else if (!w_degen_in) begin
                        // Zero delay: element (0,0) comes straight from the inputs.
                        w_state_nxt = ST_RUN;
                        w_addr_nxt  = start;
                        w_en_nxt    = w_en_first_in;
                    end
                end
            end
            ST_WAIT: begin
                if (w_dly_tc) begin
                    if (w_degen_cfg) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_addr_nxt  = r_start;
                        w_en_nxt    = w_en_first_cfg;
                    end
                end
            end
            ST_RUN: begin
                if (w_per_tc && w_iter_tc) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_per_tc) begin
                    w_addr_nxt = r_addr + r_shift;
                    w_en_nxt   = w_en_first_cfg;
                end else begin
                    w_addr_nxt = r_addr + r_incr;
                    w_en_nxt   = w_en_inner;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start  <= '0;
            r_incr   <= '0;
            r_shift  <= '0;
            r_per    <= '0;
            r_iter   <= '0;
            r_delay  <= '0;
            r_addr   <= '0;
            r_mem_en <= 1'b0;
        end else begin
            if (w_load_cfg) begin
                r_start <= start;
                r_incr  <= incr;
                r_shift <= shift;
                r_per   <= per;
                r_iter  <= iter;
                r_delay <= delay;
            end
            r_addr   <= w_addr_nxt;
            r_mem_en <= w_en_nxt;
        end
    end

    assign done   = (r_state == ST_IDLE);
    assign addr   = r_addr;
    assign mem_en = r_mem_en;

endmodule
`default_nettype wire

// File: tb/tb_xaddrgen_loop.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_xaddrgen_loop                                                |
// | Purpose  : Self-checking bench for xaddrgen_loop against a formula model    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_xaddrgen_loop;

    localparam int AW = 10;
    localparam int PW = 10;
    localparam int DW = 5;

    typedef xversat_pkg::xaddrgen_cfg_t cfg_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          done;
    logic [AW-1:0] start = '0;
    logic [PW-1:0] per   = '0;
    logic [PW-1:0] duty  = '0;
    logic [AW-1:0] incr  = '0;
    logic [PW-1:0] iter  = '0;
    logic [AW-1:0] shift = '0;
    logic [DW-1:0] delay = '0;
    logic [AW-1:0] addr;
    logic          mem_en;

    int n_checks = 0;
    int n_errors = 0;

    xaddrgen_loop #(.ADDR_W(AW), .PERIOD_W(PW), .DELAY_W(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .done   (done),
        .start  (start),
        .per    (per),
`ifdef XADDRGEN_LOOP_DUTY_EN
        .duty   (duty),
`endif
        .incr   (incr),
        .iter   (iter),
        .shift  (shift),
        .delay  (delay),
        .addr   (addr),
        .mem_en (mem_en)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic cfg_t mk(int s, int p, int d, int inc, int it, int sh, int dl);
        cfg_t c;
        c.start = AW'(s);
        c.per   = PW'(p);
        c.duty  = PW'(d);
        c.incr  = AW'(inc);
        c.iter  = PW'(it);
        c.shift = AW'(sh);
        c.delay = DW'(dl);
        return c;
    endfunction

    task automatic apply(input cfg_t c);
        start = c.start;
        per   = c.per;
        duty  = c.duty;
        incr  = c.incr;
        iter  = c.iter;
        shift = c.shift;
        delay = c.delay;
    endtask

    task automatic scramble();
        start = AW'($urandom);
        per   = PW'($urandom);
        duty  = PW'($urandom);
        incr  = AW'($urandom);
        iter  = PW'($urandom);
        shift = AW'($urandom);
        delay = DW'($urandom);
    endtask

    // Reference: element e = p*per + k, address from the closed-form formula.
    function automatic logic [AW-1:0] exp_addr(cfg_t c, int e);
        int p, k, inc, sh;
        logic [31:0] v;
        p   = e / int'(c.per);
        k   = e % int'(c.per);
        inc = int'($signed(c.incr));
        sh  = int'($signed(c.shift));
        v   = 32'(int'(c.start) + p * ((int'(c.per) - 1) * inc + sh) + k * inc);
        return v[AW-1:0];
    endfunction

    function automatic logic exp_en(cfg_t c, int e);
        int k;
        k = e % int'(c.per);
`ifdef XADDRGEN_LOOP_DUTY_EN
        return k < int'(c.duty);
`else
        return (k >= 0);
`endif
    endfunction

    function automatic int busy_len(cfg_t c);
        if (c.per == '0 || c.iter == '0) return int'(c.delay);
        return int'(c.delay) + int'(c.per) * int'(c.iter);
    endfunction

    // Starts a run from an idle cycle and compares every cycle up to done.
    task automatic run_and_check(input cfg_t c, input string tag, input bit busy_pulses);
        int total;
        int e;
        logic [AW-1:0] ea;
        logic ee;
        total = busy_len(c);
        apply(c);
        run = 1'b1;
        step();
        run = 1'b0;
        for (int cyc = 1; cyc <= total + 1; cyc++) begin
            n_checks++;
            if (done !== (cyc > total)) begin
                n_errors++;
                $display("FAIL %s done cyc=%0d got %b required %b", tag, cyc, done, (cyc > total));
            end
            if (cyc <= total && cyc > int'(c.delay)) begin
                e  = cyc - int'(c.delay) - 1;
                ea = exp_addr(c, e);
                ee = exp_en(c, e);
                n_checks++;
                if (addr !== ea) begin
                    n_errors++;
                    $display("FAIL %s addr cyc=%0d got %0d required %0d", tag, cyc, addr, ea);
                end
                n_checks++;
                if (mem_en !== ee) begin
                    n_errors++;
                    $display("FAIL %s mem_en cyc=%0d got %b required %b", tag, cyc, mem_en, ee);
                end
            end else begin
                n_checks++;
                if (mem_en !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s mem_en idle/wait cyc=%0d got %b required 0", tag, cyc, mem_en);
                end
            end
            if (cyc <= total) begin
                scramble();
                if (busy_pulses) run = (cyc == total) ? 1'b1 : 1'($urandom_range(0, 1));
                step();
                run = 1'b0;
            end
        end
        if (busy_pulses) begin
            step();
            n_checks++;
            if (done !== 1'b1 || mem_en !== 1'b0) begin
                n_errors++;
                $display("FAIL %s late run accepted: done=%b mem_en=%b required 1/0", tag, done, mem_en);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run = 1'b0;
        step();
        step();
        n_checks++;
        if (done !== 1'b1) begin
            n_errors++;
            $display("FAIL reset done got %b required 1", done);
        end
        n_checks++;
        if (mem_en !== 1'b0) begin
            n_errors++;
            $display("FAIL reset mem_en got %b required 0", mem_en);
        end
        n_checks++;
        if (addr !== '0) begin
            n_errors++;
            $display("FAIL reset addr got %0d required 0", addr);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        run_and_check(mk(4, 3, 3, 1, 2, 2, 0), "basic", 1'b0);
        run_and_check(mk(4, 3, 3, 1, 2, 2, 3), "basic_delay", 1'b0);
    endtask

    task automatic test_duty();
        run_and_check(mk(0, 4, 2, 1, 1, 0, 0), "duty", 1'b0);
        run_and_check(mk(10, 3, 0, 2, 2, 5, 1), "duty_zero", 1'b0);
    endtask

    task automatic test_wrap();
        run_and_check(mk(1022, 4, 4, 1, 1, 0, 0), "wrap_up", 1'b0);
        run_and_check(mk(1, 4, 4, 'h3FF, 1, 0, 0), "wrap_down", 1'b0);
    endtask

    task automatic test_degenerate();
        run_and_check(mk(7, 0, 3, 1, 5, 0, 0), "per_zero", 1'b0);
        run_and_check(mk(7, 5, 3, 1, 0, 0, 0), "iter_zero", 1'b0);
        run_and_check(mk(7, 0, 3, 1, 5, 0, 2), "per_zero_delay", 1'b0);
    endtask

    task automatic test_abort();
        cfg_t c;
        c = mk(4, 3, 3, 1, 2, 2, 0);
        apply(c);
        run = 1'b1;
        step();
        run = 1'b0;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            n_checks++;
            if (addr !== exp_addr(c, cyc - 1)) begin
                n_errors++;
                $display("FAIL abort pre addr cyc=%0d got %0d required %0d", cyc, addr, exp_addr(c, cyc - 1));
            end
            if (cyc < 3) step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (done !== 1'b1 || mem_en !== 1'b0 || addr !== '0) begin
            n_errors++;
            $display("FAIL abort state got done=%b mem_en=%b addr=%0d required 1/0/0", done, mem_en, addr);
        end
        step();
        n_checks++;
        if (done !== 1'b1) begin
            n_errors++;
            $display("FAIL abort stays idle got done=%b required 1", done);
        end
        run_and_check(mk(100, 2, 1, 3, 3, 'h3FE, 0), "after_abort", 1'b0);
    endtask

    task automatic test_busy_run();
        run_and_check(mk(4, 3, 3, 1, 2, 2, 1), "busy_run", 1'b1);
        run_and_check(mk(50, 4, 2, 'h3FF, 2, 9, 2), "busy_run2", 1'b1);
    endtask

    task automatic test_rst_run();
        apply(mk(4, 3, 3, 1, 2, 2, 0));
        rst = 1'b1;
        run = 1'b1;
        step();
        rst = 1'b0;
        run = 1'b0;
        n_checks++;
        if (done !== 1'b1 || mem_en !== 1'b0 || addr !== '0) begin
            n_errors++;
            $display("FAIL rst_run got done=%b mem_en=%b addr=%0d required 1/0/0", done, mem_en, addr);
        end
        step();
        n_checks++;
        if (done !== 1'b1 || mem_en !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_run idle got done=%b mem_en=%b required 1/0", done, mem_en);
        end
    endtask

    task automatic test_back_to_back();
        run_and_check(mk(200, 2, 1, 4, 2, 1, 0), "b2b_a", 1'b0);
        run_and_check(mk(300, 3, 2, 'h3FD, 1, 0, 0), "b2b_b", 1'b0);
        run_and_check(mk(5, 1, 1, 7, 3, 2, 1), "b2b_c", 1'b0);
    endtask

    task automatic test_random();
        cfg_t c;
        for (int i = 0; i < 30; i++) begin
            c = mk(int'($urandom_range(0, 1023)), int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 6)), int'($urandom_range(0, 1023)),
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 1023)),
                   int'($urandom_range(0, 4)));
            run_and_check(c, "random", 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duty();
        test_wrap();
        test_degenerate();
        test_abort();
        test_busy_run();
        test_rst_run();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
